// File: rtl/bali_mem_pkg.sv
// Shared types and constants for the data-RAM port arbiter.
//   arb_state_t : arbiter FSM states
//   mem_addr_t  : RAM word address
//   mem_word_t  : RAM data word
//   REQ_*       : requester indices of the CPU memory clients
//   idx_width() : width of an index into n items (never below 1)
package bali_mem_pkg;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 32;
    localparam int NUM_REQ    = 3;

    localparam int REQ_STACK  = 0;  // eval-stack spill
    localparam int REQ_LVA    = 1;  // local-variable array
    localparam int REQ_STATIC = 2;  // static array

    typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
    typedef logic [MEM_DATA_W-1:0] mem_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selector.
// Searches valid_i starting at ptr_i+1 (mod NREQ) and returns the first hit.
//   valid_i  in   NREQ    candidate requests
//   ptr_i    in   IDX_W   index of the most recent winner
//   grant_o  out  NREQ    one-hot winner (zero when nothing is valid)
//   idx_o    out  IDX_W   binary index of the winner
//   any_o    out  1       some request is valid
module rr_picker #(
    parameter int NREQ  = 3,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = ptr_i;
        for (int off = 0; off < NREQ; off++) begin
            // Step the candidate with an explicit wrap so NREQ need not be a power of two.
            cand = (cand == IDX_W'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port data RAM between the CPU memory
// clients (0 = eval-stack spill, 1 = local-variable array, 2 = static array).
// Round-robin choice, one transaction in flight, one-cycle response pulse.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/we/lock   per-requester request, write flag, lock request
//   req_addr/wdata      per-requester word address and write data
//   req_ready           one-hot accept (combinational, only in IDLE)
//   rsp_valid/rsp_rdata one-hot completion pulse; last read data (held)
//   mem_en/we/addr/wdata registered RAM command, high for one cycle
//   mem_rdata           RAM read data, MEM_LAT cycles after mem_en
//   busy                a transaction is in progress
//
// Build option: define ARB_LOCK_EN to let an accepted request with req_lock=1
// reserve the port for its requester until that requester is accepted with
// req_lock=0. Without it req_lock is ignored.
module mem_port_arbiter
    import bali_mem_pkg::*;
#(
    parameter int NREQ    = NUM_REQ,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int DATA_W  = MEM_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_we,
    input  logic [NREQ-1:0]             req_lock,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NREQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy
);

    localparam int IDX_W = idx_width(NREQ);
    localparam int CNT_W = idx_width(MEM_LAT);

    if (NREQ < 2) begin : g_bad_nreq
        $fatal(1, "mem_port_arbiter: NREQ must be >= 2");
    end
    if (MEM_LAT < 1) begin : g_bad_lat
        $fatal(1, "mem_port_arbiter: MEM_LAT must be >= 1");
    end

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [NREQ-1:0]  pick_valid;
    logic [NREQ-1:0]  pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

`ifdef ARB_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_id_q, lock_id_d;

    // While locked, only the owner is presented to the picker.
    always_comb begin
        pick_valid = req_valid;
        if (lock_q) begin
            pick_valid            = '0;
            pick_valid[lock_id_q] = req_valid[lock_id_q];
        end
    end
`else
    logic unused_lock;
    assign pick_valid  = req_valid;
    assign unused_lock = ^req_lock;
`endif

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid_i (pick_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
`ifdef ARB_LOCK_EN
        lock_d      = lock_q;
        lock_id_d   = lock_id_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // Accept: the RAM command registers double as the latched payload.
                    state_d     = ISSUE;
                    id_d        = pick_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = req_we[pick_idx];
                    mem_addr_d  = req_addr[pick_idx];
                    mem_wdata_d = req_wdata[pick_idx];
`ifdef ARB_LOCK_EN
                    if (!lock_q) ptr_d = pick_idx;
                    // Only the owner can win while locked, so this both sets and releases.
                    lock_d    = req_lock[pick_idx];
                    lock_id_d = pick_idx;
`else
                    ptr_d = pick_idx;
`endif
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = mem_we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(MEM_LAT - 1)) begin
                    rdata_d = mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= IDX_W'(NREQ - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE) req_ready = pick_grant;
        if (state_q == RESP) rsp_valid[id_q] = 1'b1;
    end

    assign rsp_rdata = rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// random traffic, all outputs compared every cycle against a transaction-level
// model (winner search, completion-cycle arithmetic, word array).
module tb_mem_port_arbiter;
    import bali_mem_pkg::*;

    localparam int NREQ    = 3;
    localparam int MEM_LAT = 1;

    logic                            clk;
    logic                            rst;
    logic [NREQ-1:0]                 req_valid;
    logic [NREQ-1:0]                 req_we;
    logic [NREQ-1:0]                 req_lock;
    logic [NREQ-1:0][MEM_ADDR_W-1:0] req_addr;
    logic [NREQ-1:0][MEM_DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]                 req_ready;
    logic [NREQ-1:0]                 rsp_valid;
    mem_word_t                       rsp_rdata;
    logic                            mem_en;
    logic                            mem_we;
    mem_addr_t                       mem_addr;
    mem_word_t                       mem_wdata;
    mem_word_t                       mem_rdata;
    logic                            busy;

    mem_port_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (MEM_ADDR_W),
        .DATA_W  (MEM_DATA_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM environment: MEM_LAT-deep read pipe, random junk whenever no read data is due.
    mem_word_t          ram [16] = '{default: '0};
    logic [MEM_LAT-1:0] rd_v = '0;
    mem_word_t          rd_d [MEM_LAT];
    mem_word_t          junk_q = '0;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr[3:0]] <= mem_wdata;
        rd_v[0] <= mem_en && !mem_we;
        rd_d[0] <= ram[mem_addr[3:0]];
        for (int k = 1; k < MEM_LAT; k++) begin
            rd_v[k] <= rd_v[k-1];
            rd_d[k] <= rd_d[k-1];
        end
        junk_q <= $urandom;
    end
    assign mem_rdata = rd_v[MEM_LAT-1] ? rd_d[MEM_LAT-1] : junk_q;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one outstanding transaction described by its accept
    // cycle and completion cycle.
    mem_word_t model_mem [16] = '{default: '0};
    int        m_ptr, m_id, m_acc_cyc, m_resp_cyc;
    bit        m_pend, m_we, m_lock;
    int        m_lock_id;
    mem_addr_t m_addr;
    mem_word_t m_wdata, m_rd_exp, m_hold;

    // Observations of the DUT for the directed latency/order checks.
    int        dut_grants [$];
    int        last_grant_cyc, last_memwe_cyc, last_rsp_cyc, rsp_cnt;
    logic [NREQ-1:0] last_rsp_val;
    mem_word_t last_rsp_data;

    task automatic model_reset();
        m_pend    = 1'b0;
        m_ptr     = NREQ - 1;
        m_lock    = 1'b0;
        m_lock_id = 0;
        m_hold    = '0;
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_req_ready"}, 64'(req_ready), 64'(0));
        check({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        check({pfx, "_mem_en"},    64'(mem_en),    64'(0));
        check({pfx, "_mem_we"},    64'(mem_we),    64'(0));
        check({pfx, "_mem_addr"},  64'(mem_addr),  64'(0));
        check({pfx, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        check({pfx, "_busy"},      64'(busy),      64'(0));
    endtask

    // Called mid-cycle: log DUT activity, compare against the model, then
    // apply the accept (if any) that happens at the coming edge.
    task automatic eval_cycle(output int w);
        int              win;
        int              c;
        int              gi;
        bit              issue;
        logic [NREQ-1:0] gv;

        if (m_pend && cyc > m_resp_cyc) m_pend = 1'b0;

        gv = req_valid & req_ready;
        if (gv != '0) begin
            gi = 0;
            for (int i = 0; i < NREQ; i++) if (gv[i]) gi = i;
            dut_grants.push_back(gi);
            last_grant_cyc = cyc;
        end
        if (mem_en && mem_we) last_memwe_cyc = cyc;
        if (rsp_valid != '0) begin
            rsp_cnt++;
            last_rsp_cyc  = cyc;
            last_rsp_val  = rsp_valid;
            last_rsp_data = rsp_rdata;
        end

        win = -1;
        if (!m_pend) begin
            for (int off = 1; off <= NREQ; off++) begin
                c = (m_ptr + off) % NREQ;
                if (win < 0 && req_valid[c] && (!m_lock || c == m_lock_id)) win = c;
            end
        end

        if (m_pend && cyc == m_resp_cyc && !m_we) m_hold = m_rd_exp;
        issue = m_pend && (cyc == m_acc_cyc + 1);

        check("req_ready", 64'(req_ready), (win >= 0) ? 64'(1) << win : 64'(0));
        check("busy",      64'(busy),      64'(m_pend));
        check("mem_en",    64'(mem_en),    64'(issue));
        check("mem_we",    64'(mem_we),    64'(issue && m_we));
        if (issue) begin
            check("mem_addr",  64'(mem_addr),  64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        check("rsp_valid", 64'(rsp_valid),
              (m_pend && cyc == m_resp_cyc) ? 64'(1) << m_id : 64'(0));
        check("rsp_rdata", 64'(rsp_rdata), 64'(m_hold));

        if (win >= 0) begin
            m_pend     = 1'b1;
            m_acc_cyc  = cyc;
            m_id       = win;
            m_we       = req_we[win];
            m_addr     = req_addr[win];
            m_wdata    = req_wdata[win];
            m_resp_cyc = cyc + 2 + (m_we ? 0 : MEM_LAT);
            if (m_we) model_mem[m_addr[3:0]] = m_wdata;
            else      m_rd_exp = model_mem[m_addr[3:0]];
            if (!m_lock) m_ptr = win;
`ifdef ARB_LOCK_EN
            m_lock    = req_lock[win];
            m_lock_id = win;
`endif
        end
        w = win;
    endtask

    task automatic step(output int w);
        @(negedge clk);
        eval_cycle(w);
        @(posedge clk);
        cyc++;
        #1;
        if (w >= 0) begin
            req_valid[w] = 1'b0;
            req_lock[w]  = 1'b0;
        end
    endtask

    task automatic post(input int i, input logic we, input mem_addr_t addr,
                        input mem_word_t data, input logic lock);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = addr;
        req_wdata[i] = data;
        req_lock[i]  = lock;
    endtask

    task automatic drain(input int budget);
        int  w;
        int  n;
        bit  still;
        n = 0;
        while ((req_valid != '0 || m_pend) && n < budget) begin
            step(w);
            n++;
        end
        still = (req_valid != '0) || m_pend;
        if (still) check("drain_timeout", 64'(still), 64'(0));
    endtask

    task automatic wait_accept(input string tag, input int id, input int budget);
        int w;
        int n;
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < budget) begin
            step(w);
            got = (w == id);
            n++;
        end
        check(tag, 64'(got), 64'(1));
    endtask

    initial begin
        int w;
        int n;
        int n0;
        int rsp_before;
        int exp_rr [4];
        int exp_lk [5];

        rst       = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_cnt   = 0;
        last_grant_cyc = 0;
        last_memwe_cyc = 0;
        last_rsp_cyc   = 0;
        last_rsp_val   = '0;
        last_rsp_data  = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b1;

        // All three requesters valid continuously from reset: 0,1,2,0.
        dut_grants.delete();
        for (int i = 0; i < NREQ; i++) post(i, 1'b1, mem_addr_t'(8 + i), $urandom, 1'b0);
        n = 0;
        while (dut_grants.size() < 4 && n < 40) begin
            step(w);
            if (w >= 0 && dut_grants.size() < 4) post(w, 1'b1, mem_addr_t'(8 + w), $urandom, 1'b0);
            n++;
        end
        drain(60);
        exp_rr = '{0, 1, 2, 0};
        check("rr_count", 64'(dut_grants.size() >= 4), 64'(1));
        for (int k = 0; k < 4; k++)
            if (k < dut_grants.size()) check("rr_order", 64'(dut_grants[k]), 64'(exp_rr[k]));

        // Single write from requester 1.
        post(REQ_LVA, 1'b1, 16'h0001, 32'hffffcafe, 1'b0);
        drain(20);
        check("wr_memwe_lat", 64'(last_memwe_cyc - last_grant_cyc), 64'(1));
        check("wr_rsp_lat",   64'(last_rsp_cyc - last_grant_cyc),   64'(2));
        check("wr_rsp_id",    64'(last_rsp_val),                    64'(3'b010));

        // Read it back from requester 2.
        post(REQ_STATIC, 1'b0, 16'h0001, '0, 1'b0);
        drain(20);
        check("rd_rsp_lat",   64'(last_rsp_cyc - last_grant_cyc), 64'(2 + MEM_LAT));
        check("rd_rsp_id",    64'(last_rsp_val),                  64'(3'b100));
        check("rd_rsp_data",  64'(last_rsp_data),                 64'(32'hffffcafe));

        // Write then read the same address from different requesters.
        post(REQ_STACK, 1'b1, 16'h0005, 32'hcafebabe, 1'b0);
        drain(20);
        post(REQ_LVA, 1'b0, 16'h0005, '0, 1'b0);
        drain(20);
        check("wr_rd_id",   64'(last_rsp_val),  64'(3'b010));
        check("wr_rd_data", 64'(last_rsp_data), 64'(32'hcafebabe));

        // Reset asserted while a read sits in WAIT.
        post(REQ_STATIC, 1'b0, 16'h0001, '0, 1'b0);
        wait_accept("rst_accept", REQ_STATIC, 10);
        step(w);
        #2 rst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        model_reset();
        rsp_before = rsp_cnt;
        step(w);
        rst = 1'b1;
        repeat (6) step(w);
        check("rst_no_rsp", 64'(rsp_cnt - rsp_before), 64'(0));

`ifdef ARB_LOCK_EN
        // Requester 0 locks; 1 and 2 wait until it releases.
        dut_grants.delete();
        post(REQ_STACK,  1'b1, 16'h0002, $urandom, 1'b1);
        post(REQ_LVA,    1'b1, 16'h0003, $urandom, 1'b0);
        post(REQ_STATIC, 1'b0, 16'h0002, '0,       1'b0);
        n  = 0;
        n0 = 0;
        while (dut_grants.size() < 5 && n < 80) begin
            step(w);
            if (w == 0) begin
                n0++;
                if (n0 < 3) post(REQ_STACK, 1'b1, 16'h0002, $urandom, (n0 < 2));
            end
            n++;
        end
        drain(40);
        exp_lk = '{0, 0, 0, 1, 2};
        check("lock_count", 64'(dut_grants.size()), 64'(5));
        for (int k = 0; k < 5; k++)
            if (k < dut_grants.size()) check("lock_order", 64'(dut_grants[k]), 64'(exp_lk[k]));
`endif

        // Random traffic.
        for (int t = 0; t < 1500; t++) begin
            step(w);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 99) < 35)
                    post(i, 1'($urandom_range(0, 1)), mem_addr_t'($urandom_range(0, 15)),
                         $urandom, ($urandom_range(0, 99) < 15));
            end
        end
        drain(300);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
